hex_display_scheduler: RTL

//  Time-shares one external 4-bit -> 7-segment decoder across DIGITS HEX displays on the DE1-SoC.
//  - On a load request, walks the captured nibbles through the shared decoder one digit per cycle.
//  - Builds a new frame, commits it atomically, then drives the per-digit segment outputs.
//  - Adds leading-zero blanking, per-digit blinking and a one-deep pending-load buffer.

---
 rtl/hex_display_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Shares one external 4-bit -> 7-segment decoder across DIGITS HEX displays.
//   A load captures a value. The nibbles are then walked through the decoder one
//   digit per cycle, from the most significant digit down to digit 0. The decoded
//   frame is committed to the display registers in one step. The block also
//   provides leading-zero blanking, per-digit blinking and a one-deep pending-load
//   buffer.
// Ports
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   load        capture value/blank_lz this cycle
//   value       packed nibbles, digit 0 = value[3:0]
//   blank_lz    blank the leading zeros of this load
//   blink_mask  per-digit blink enable (registered internally)
//   dec_in      nibble presented to the shared decoder (registered)
//   dec_seg     decoder result for dec_in, active-low {g,f,e,d,c,b,a}
//   hex_out     registered segments, digit i = hex_out[7i+6:7i], active-low
//   busy        registered, high while not IDLE
//   done        one-cycle pulse after the frame commit
module hex_display_scheduler #(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [3:0]            dec_in,
    input  logic [6:0]            dec_seg,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  busy,
    output logic                  done
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                      state_q;
    logic [IW-1:0]               idx_q;
    logic [DIGITS-1:0][3:0]      shadow_q;
    logic                        lz_active_q;
    logic [DIGITS-1:0][6:0]      frame_q;
    logic [DIGITS-1:0][6:0]      disp_q;
    logic [DIGITS-1:0][6:0]      hex_q;
    logic                        pend_vld_q;
    logic [DIGITS-1:0][3:0]      pend_val_q;
    logic                        pend_lz_q;
    logic [3:0]                  dec_in_q;
    logic                        busy_q;
    logic                        done_q;
    logic [DIGITS-1:0]           blink_mask_q;
    logic [CW-1:0]               cnt_q;
    logic                        blink_phase_q;

    // A live load always beats the pending entry because it is the latest request.
    logic [DIGITS-1:0][3:0]      src_val_d;
    logic                        src_lz_d;
    logic [3:0]                  nib;

    always_comb begin
        src_val_d = load ? value : pend_val_q;
        src_lz_d  = load ? blank_lz : pend_lz_q;
        nib       = shadow_q[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            lz_active_q <= 1'b0;
            frame_q     <= {DIGITS{BLANK}};
            disp_q      <= {DIGITS{BLANK}};
            pend_vld_q  <= 1'b0;
            pend_val_q  <= '0;
            pend_lz_q   <= 1'b0;
            dec_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load && state_q != IDLE) begin
                pend_vld_q <= 1'b1;
                pend_val_q <= value;
                pend_lz_q  <= blank_lz;
            end
            case (state_q)
                IDLE: begin
                    if (load || pend_vld_q) begin
                        shadow_q    <= src_val_d;
                        lz_active_q <= src_lz_d;
                        idx_q       <= IW'(DIGITS-1);
                        // The first decoder nibble is registered here so it is stable for the whole first SCAN cycle.
                        dec_in_q    <= src_val_d[DIGITS-1];
                        pend_vld_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    // Digit 0 is never blanked, so an all-zero value still shows a single 0.
                    frame_q[idx_q] <= (lz_active_q && nib == 4'd0 && idx_q != '0) ? BLANK : dec_seg;
                    if (nib != 4'd0) lz_active_q <= 1'b0;
                    if (idx_q == '0) begin
                        state_q <= COMMIT;
                    end else begin
                        idx_q    <= idx_q - IW'(1);
                        dec_in_q <= shadow_q[idx_q - IW'(1)];
                    end
                end
                COMMIT: begin
                    disp_q  <= frame_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Free-running blink timebase. A phase of 0 means the digits are visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            blink_phase_q <= 1'b0;
            blink_mask_q  <= '0;
        end else begin
            blink_mask_q <= blink_mask;
            if (cnt_q == CW'(BLINK_DIV-1)) begin
                cnt_q         <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) hex_q[g] <= BLANK;
            else        hex_q[g] <= (blink_mask_q[g] & blink_phase_q) ? BLANK : disp_q[g];
        end
    end

    assign hex_out = hex_q;
    assign dec_in  = dec_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule
